// File: rtl/key_progress_pkg.sv
// Shared game-state encodings and click hit windows, used by key_progress and the object drawer.
package key_progress_pkg;

  typedef enum logic [3:0] {
    TITLE    = 4'd0,
    STAFF    = 4'd1,
    STAGE1   = 4'd2,
    SUCCESS1 = 4'd3,
    STAGE2   = 4'd4,
    SUCCESS2 = 4'd5,
    STAGE3   = 4'd6,
    SUCCESS3 = 4'd7,
    FAIL     = 4'd8
  } game_state_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    COOL  = 2'd2,
    DONE  = 2'd3
  } kp_state_e;

  // Inclusive low bound, exclusive high bound, 320x240 coordinate space.
  typedef struct packed {
    logic [8:0] x_lo;
    logic [8:0] x_hi;
    logic [8:0] y_lo;
    logic [8:0] y_hi;
  } win_t;

  localparam win_t KEY1_WIN   = '{x_lo: 9'd65,  x_hi: 9'd85,  y_lo: 9'd35,  y_hi: 9'd55};
  localparam win_t KEY2_WIN   = '{x_lo: 9'd230, x_hi: 9'd250, y_lo: 9'd35,  y_hi: 9'd55};
  localparam win_t KEY3_WIN   = '{x_lo: 9'd230, x_hi: 9'd250, y_lo: 9'd205, y_hi: 9'd225};
  localparam win_t SWITCH_WIN = '{x_lo: 9'd180, x_hi: 9'd200, y_lo: 9'd135, y_hi: 9'd155};

  function automatic logic in_win(input logic [8:0] x, input logic [8:0] y, input win_t w);
    return (x >= w.x_lo) && (x < w.x_hi) && (y >= w.y_lo) && (y < w.y_hi);
  endfunction

  // Window of the next key to find; index 3 has no key and maps to an empty window.
  function automatic win_t key_win(input logic [1:0] idx);
    case (idx)
      2'd0:    return KEY1_WIN;
      2'd1:    return KEY2_WIN;
      2'd2:    return KEY3_WIN;
      default: return '{x_lo: 9'd0, x_hi: 9'd0, y_lo: 9'd0, y_hi: 9'd0};
    endcase
  endfunction

  function automatic logic is_stage(input logic [3:0] s);
    return (s == STAGE1) || (s == STAGE2) || (s == STAGE3);
  endfunction

endpackage

// File: rtl/key_progress_if.sv
// Game-state / click inputs and key-progress outputs exchanged with key_progress.
interface key_progress_if;
  logic [3:0] state;
  logic       click;
  logic [8:0] click_x;
  logic [8:0] click_y;
  logic [1:0] key_find;
  logic       isDark;
  logic       stage_clear;

  modport master (output state, click, click_x, click_y,
                  input  key_find, isDark, stage_clear);
  modport slave  (input  state, click, click_x, click_y,
                  output key_find, isDark, stage_clear);
endinterface

// File: rtl/key_progress_click_sync.sv
// Two-flop synchroniser for the raw click level plus a rising-edge detector.
module click_sync (
  input  logic clk,
  input  logic rst,
  input  logic click,
  output logic rise
);

  logic s1, s2, s3;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= click;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign rise = s2 & ~s3;

endmodule

// File: rtl/key_progress.sv
// Tracks keys found and the room light per stage from clicks, with a post-hit cooldown.
module key_progress
  import key_progress_pkg::*;
#(
  parameter int COOLDOWN = 25_000_000
) (
  input  logic           clk,
  input  logic           rst,
  key_progress_if.slave  bus
);

  localparam int                CNT_W    = $clog2(COOLDOWN + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(COOLDOWN - 1);

  logic rise;

  click_sync u_click_sync (
    .clk   (clk),
    .rst   (rst),
    .click (bus.click),
    .rise  (rise)
  );

  // Stage p0: click edge and coordinates captured together
  logic       vld_p0;
  logic [8:0] x_p0, y_p0;
  logic [3:0] prev_state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p0     <= 1'b0;
      x_p0       <= '0;
      y_p0       <= '0;
      prev_state <= TITLE;
    end else begin
      vld_p0     <= rise;
      prev_state <= bus.state;
      if (rise) begin
        x_p0 <= bus.click_x;
        y_p0 <= bus.click_y;
      end
    end
  end

  kp_state_e        fsm, fsm_nxt;
  logic [1:0]       key_q, key_nxt;
  logic             dark_q, dark_nxt;
  logic             clr_q, clr_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;

  logic changed, in_stage, stage2, key_ok, sw_ok;

  assign changed  = (bus.state != prev_state);
  assign in_stage = is_stage(bus.state);
  assign stage2   = (bus.state == STAGE2);
  // Key hit outranks the switch; in STAGE2 keys are only visible in the dark.
  assign key_ok   = vld_p0 && (key_q != 2'd3) && in_win(x_p0, y_p0, key_win(key_q))
                    && (!stage2 || dark_q);
  assign sw_ok    = vld_p0 && stage2 && in_win(x_p0, y_p0, SWITCH_WIN);

  // Stage p1: registered FSM and outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fsm    <= IDLE;
      key_q  <= '0;
      dark_q <= 1'b0;
      clr_q  <= 1'b0;
      cnt    <= '0;
    end else begin
      fsm    <= fsm_nxt;
      key_q  <= key_nxt;
      dark_q <= dark_nxt;
      clr_q  <= clr_nxt;
      cnt    <= cnt_nxt;
    end
  end

  always_comb begin
    fsm_nxt = fsm;
    if (changed) begin
      fsm_nxt = in_stage ? ARMED : IDLE;
    end else if (!in_stage) begin
      fsm_nxt = IDLE;
    end else begin
      case (fsm)
        IDLE:  fsm_nxt = ARMED;
        ARMED: begin
          if (key_ok)     fsm_nxt = (key_q == 2'd2) ? DONE : COOL;
          else if (sw_ok) fsm_nxt = COOL;
        end
        COOL:  if (cnt == '0) fsm_nxt = ARMED;
        DONE:  fsm_nxt = DONE;
        default: fsm_nxt = IDLE;
      endcase
    end
  end

  always_comb begin
    key_nxt  = key_q;
    dark_nxt = dark_q;
    clr_nxt  = 1'b0;
    cnt_nxt  = cnt;
    if (changed || !in_stage) begin
      key_nxt  = '0;
      dark_nxt = 1'b0;
      cnt_nxt  = '0;
    end else begin
      case (fsm)
        ARMED: begin
          if (key_ok) begin
            key_nxt = key_q + 2'd1;
            clr_nxt = (key_q == 2'd2);
            cnt_nxt = CNT_LOAD;
          end else if (sw_ok) begin
            dark_nxt = ~dark_q;
            cnt_nxt  = CNT_LOAD;
          end
        end
        COOL:    if (cnt != '0) cnt_nxt = cnt - CNT_W'(1);
        default: ;
      endcase
    end
  end

  assign bus.key_find    = key_q;
  assign bus.isDark      = dark_q;
  assign bus.stage_clear = clr_q;

endmodule
